// File: rtl/matmul_result_collector_pkg.sv
// matmul_result_collector_pkg: default geometry, FSM state type and element index helpers
package matmul_result_collector_pkg;
  localparam int DW = 8;
  localparam int BW = 16;
  localparam int MAX_DIM = BW / DW;
  localparam int NE = MAX_DIM * MAX_DIM;
  localparam int EW = 2 * DW;
  typedef enum logic [1:0] {IDLE, PROC, DONE} state_e;
  function automatic int idx_row(input int idx, input int md);
    return idx % md;
  endfunction
  function automatic int idx_col(input int idx, input int md);
    return idx / md;
  endfunction
endpackage

// File: rtl/matmul_result_collector_if.sv
// matmul_result_collector_if: scratchpad read port (rd_en/rd_slot/rd_idx in, rd_data/rd_valid out); master = bus side, slave = collector
interface matmul_result_collector_if
  import matmul_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DW,
  parameter int BUS_WIDTH = BW,
  parameter int SP_NTARGETS = 4
);
  localparam int MD = BUS_WIDTH / DATA_WIDTH;
  logic rd_en;
  logic [$clog2(SP_NTARGETS)-1:0] rd_slot;
  logic [$clog2(MD*MD)-1:0] rd_idx;
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic rd_valid;
  modport master(output rd_en, rd_slot, rd_idx, input rd_data, rd_valid);
  modport slave(input rd_en, rd_slot, rd_idx, output rd_data, rd_valid);
endinterface

// File: rtl/matmul_scratchpad_mem.sv
// matmul_scratchpad_mem: S x N x W register file; comb bias read (b_*), registered read (rd_*), write (we/w_*), zero on rst_i
module matmul_scratchpad_mem #(
  parameter int W = 16,
  parameter int N = 4,
  parameter int S = 4,
  localparam int IW = $clog2(N),
  localparam int SW = $clog2(S)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [SW-1:0] b_slot,
  input  logic [IW-1:0] b_idx,
  output logic [W-1:0]  b_data,
  input  logic          rd_en,
  input  logic [SW-1:0] rd_slot,
  input  logic [IW-1:0] rd_idx,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  input  logic          we,
  input  logic [SW-1:0] w_slot,
  input  logic [IW-1:0] w_idx,
  input  logic [W-1:0]  w_data
);
  logic [W-1:0] mem [S][N];
  assign b_data = mem[b_slot][b_idx];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int s = 0; s < S; s++)
        for (int n = 0; n < N; n++)
          mem[s][n] <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (we) mem[w_slot][w_idx] <= w_data;
      rd_valid <= rd_en;
      if (rd_en) rd_data <= mem[rd_slot][rd_idx];
    end
endmodule

// File: rtl/matmul_result_collector.sv
// matmul_result_collector: captures C/flags on finish edge, optional bias add, writes a scratchpad slot; rd port via interface
module matmul_result_collector
  import matmul_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DW,
  parameter int BUS_WIDTH = BW,
  parameter int SP_NTARGETS = 4,
  localparam int MD = BUS_WIDTH / DATA_WIDTH,
  localparam int N = MD * MD,
  localparam int W = 2 * DATA_WIDTH,
  localparam int IW = $clog2(N),
  localparam int SW = $clog2(SP_NTARGETS)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           finish_mul_i,
  input  logic [N*W-1:0] c_matrix_i,
  input  logic [N-1:0]   flags_i,
  input  logic [2:0]     n_dim_i,
  input  logic [2:0]     m_dim_i,
  input  logic           bias_i,
  input  logic [SW-1:0]  src_slot_i,
  input  logic [SW-1:0]  dst_slot_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [N-1:0]   flags_o,
  output logic           missed_o,
  matmul_result_collector_if.slave rd
);
  state_e state;
  logic finish_d, bias_q;
  logic [IW-1:0] idx;
  logic [N*W-1:0] c_q;
  logic [N-1:0] f_q, acc;
  logic [2:0] n_q, m_q;
  logic [SW-1:0] src_q, dst_q;
  logic [W-1:0] a, b, b_data, s, w_data;
  logic rise, in_rng, ovf, w_flag;
  assign rise = finish_mul_i & ~finish_d;
  assign busy_o = state != IDLE;
  always_comb begin
    in_rng = idx_row(int'(idx), MD) < int'(n_q) && idx_col(int'(idx), MD) < int'(m_q);
    a = c_q[idx*W +: W];
    b = bias_q ? b_data : '0;
    s = a + b;
    ovf = a[W-1] == b[W-1] && s[W-1] != a[W-1];
    w_data = in_rng ? s : '0;
    w_flag = in_rng & (f_q[idx] | ovf);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      finish_d <= 1'b0;
      idx <= '0;
      c_q <= '0;
      f_q <= '0;
      n_q <= '0;
      m_q <= '0;
      bias_q <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      acc <= '0;
      flags_o <= '0;
      done_o <= 1'b0;
      missed_o <= 1'b0;
    end else begin
      finish_d <= finish_mul_i;
      done_o <= 1'b0;
      if (rise && state != IDLE) missed_o <= 1'b1;
      case (state)
        IDLE: if (rise) begin
          c_q <= c_matrix_i;
          f_q <= flags_i;
          n_q <= n_dim_i;
          m_q <= m_dim_i;
          bias_q <= bias_i;
          src_q <= src_slot_i;
          dst_q <= dst_slot_i;
          idx <= '0;
          state <= PROC;
        end
        PROC: begin
          acc[idx] <= w_flag;
          idx <= idx + IW'(1);
          if (idx == IW'(N - 1)) state <= DONE;
        end
        DONE: begin
          flags_o <= acc;
          done_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // bias operand is read combinationally before the registered write lands, so src==dst accumulates in place
  matmul_scratchpad_mem #(.W(W), .N(N), .S(SP_NTARGETS)) u_mem (
    .clk_i(clk_i), .rst_i(rst_i),
    .b_slot(src_q), .b_idx(idx), .b_data(b_data),
    .rd_en(rd.rd_en), .rd_slot(rd.rd_slot), .rd_idx(rd.rd_idx), .rd_data(rd.rd_data), .rd_valid(rd.rd_valid),
    .we(state == PROC), .w_slot(dst_q), .w_idx(idx), .w_data(w_data)
  );
endmodule
